// File: rtl/cordic_sched_if.sv
// Requester and engine signals of the shared CORDIC scheduler.
// The scheduler is the slave; clients and the engine together form the master side.
interface cordic_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] theta_in;
  logic [8*NREQ-1:0] x_in;
  logic [8*NREQ-1:0] y_in;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [15:0]       res_ax;
  logic [15:0]       res_ay;
  logic [IDW-1:0]    res_id;
  logic              busy;
  logic              eng_load;
  logic [7:0]        eng_theta;
  logic [7:0]        eng_x;
  logic [7:0]        eng_y;
  logic [15:0]       eng_ax;
  logic [15:0]       eng_ay;

  modport master (
    output req, theta_in, x_in, y_in, eng_ax, eng_ay,
    input  grant, done, res_ax, res_ay, res_id, busy,
           eng_load, eng_theta, eng_x, eng_y
  );

  modport slave (
    input  req, theta_in, x_in, y_in, eng_ax, eng_ay,
    output grant, done, res_ax, res_ay, res_id, busy,
           eng_load, eng_theta, eng_x, eng_y
  );
endinterface

// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one CORDIC rotation engine among NREQ clients.
// One job per ITER+4 cycles: IDLE (arbitrate), LOAD, ITER+1 RUN cycles, DONE.
// done and res_* become visible together, in the cycle after the DONE state.
module cordic_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int ITER = 8
) (
  input logic           Clk,
  input logic           reset,
  cordic_sched_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0]      CNT_END = 4'(ITER);
  localparam logic [IDW-1:0]  LAST    = IDW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE     = NREQ'(1);

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [IDW-1:0]        rr_ptr;
  logic [IDW-1:0]        g;
  logic [IDW-1:0]        win;
  logic                  found;
  logic [2*NREQ-1:0]     req_dbl;
  logic [NREQ-1:0]       req_rot;
  logic [NREQ-1:0][7:0]  th_v, x_v, y_v;

  // per-requester byte lanes of the flat operand buses
  assign th_v = bus.theta_in;
  assign x_v  = bus.x_in;
  assign y_v  = bus.y_in;

  // rotate requests so bit 0 is the requester at rr_ptr; wrap comes for free
  assign req_dbl = {bus.req, bus.req} >> rr_ptr;
  assign req_rot = req_dbl[NREQ-1:0];

  assign bus.eng_load = (state == LOAD);
  assign bus.busy     = (state != IDLE);

  // first pending requester at or after rr_ptr, modulo NREQ
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        win   = IDW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  // job FSM: operands latched once at grant, result captured on exit from DONE
  always_ff @(posedge Clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      rr_ptr        <= '0;
      g             <= '0;
      bus.grant     <= '0;
      bus.done      <= '0;
      bus.eng_theta <= '0;
      bus.eng_x     <= '0;
      bus.eng_y     <= '0;
      bus.res_ax    <= '0;
      bus.res_ay    <= '0;
      bus.res_id    <= '0;
    end else begin
      bus.done <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            state         <= LOAD;
            g             <= win;
            bus.grant     <= ONE << win;
            bus.eng_theta <= th_v[win];
            bus.eng_x     <= x_v[win];
            bus.eng_y     <= y_v[win];
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          // ITER iterations plus one cycle for the engine output register
          if (cnt == CNT_END) state <= DONE;
          else                cnt   <= cnt + 4'd1;
        end
        DONE: begin
          bus.res_ax <= bus.eng_ax;
          bus.res_ay <= bus.eng_ay;
          bus.res_id <= g;
          bus.done   <= bus.grant;
          bus.grant  <= '0;
          rr_ptr     <= (g == LAST) ? '0 : g + 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_sched.sv
// Directed bench for cordic_sched: table of single jobs plus hand-written
// sequences for continuous requests, mid-job drop, operand change, reset, fairness.
module tb_cordic_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int ITER = 8;
  localparam int LAT  = ITER + 4;  // negedges from request setup to done visible

  typedef struct {
    logic [3:0] req;
    logic [7:0] th;
    logic [7:0] x;
    logic [7:0] y;
    int         id;
  } vec_t;

  logic       Clk = 1'b0;
  logic       reset;
  logic [7:0] cyc = 8'd0;
  int         checks = 0;
  int         errors = 0;
  vec_t       tv[7];

  cordic_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  cordic_sched #(.NREQ(NREQ), .IDW(IDW), .ITER(ITER)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 8'd1;

  // engine stand-in: Ax carries the cycle number so capture timing is visible
  assign bus.eng_ax = {bus.eng_x, cyc};
  assign bus.eng_ay = {bus.eng_y, bus.eng_theta};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // grant must never have more than one bit set
  always @(negedge Clk) begin
    if (reset === 1'b0) begin
      checks++;
      if (!$onehot0(bus.grant)) begin
        errors++;
        $display("FAIL grant_onehot: got %b expected one-hot or zero", bus.grant);
      end
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (bus.done == '0 && n < 40);
  endtask

  task automatic run_job(input vec_t v);
    logic [7:0]      c0;
    logic [NREQ-1:0] eg;
    int              n;
    eg = 4'b0001 << v.id;
    @(negedge Clk);
    bus.theta_in = 32'hA3A2A1A0;
    bus.x_in     = 32'hB3B2B1B0;
    bus.y_in     = 32'hC3C2C1C0;
    bus.theta_in[8*v.id +: 8] = v.th;
    bus.x_in[8*v.id +: 8]     = v.x;
    bus.y_in[8*v.id +: 8]     = v.y;
    bus.req = v.req;
    c0 = cyc;
    @(negedge Clk);
    chk("job_grant", 32'(bus.grant), 32'(eg));
    chk("job_load_hi", 32'(bus.eng_load), 32'd1);
    chk("job_busy", 32'(bus.busy), 32'd1);
    chk("job_eng_theta", 32'(bus.eng_theta), 32'(v.th));
    chk("job_eng_x", 32'(bus.eng_x), 32'(v.x));
    chk("job_eng_y", 32'(bus.eng_y), 32'(v.y));
    @(negedge Clk);
    chk("job_load_lo", 32'(bus.eng_load), 32'd0);
    n = 2;
    while (bus.done == '0 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    chk("job_latency", 32'(n), 32'(LAT));
    chk("job_done", 32'(bus.done), 32'(eg));
    chk("job_res_id", 32'(bus.res_id), 32'(v.id));
    chk("job_res_ax", 32'(bus.res_ax), 32'({v.x, 8'(c0 + 8'd11)}));
    chk("job_res_ay", 32'(bus.res_ay), 32'({v.y, v.th}));
    chk("job_grant_clr", 32'(bus.grant), 32'd0);
    bus.req = '0;
    @(negedge Clk);
    chk("job_done_pulse", 32'(bus.done), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int jobs;
    int nz;
    logic got3;

    tv[0] = '{4'b0010, 8'h20, 8'h40, 8'h00, 1};
    tv[1] = '{4'b0011, 8'h05, 8'h7F, 8'h81, 0};
    tv[2] = '{4'b1001, 8'hFF, 8'h01, 8'h80, 3};
    tv[3] = '{4'b1111, 8'h3C, 8'hC3, 8'h5A, 0};
    tv[4] = '{4'b0001, 8'h00, 8'hFF, 8'hFF, 0};
    tv[5] = '{4'b1100, 8'h12, 8'h34, 8'h56, 2};
    tv[6] = '{4'b0110, 8'h9A, 8'hBC, 8'hDE, 1};

    reset = 1'b1;
    bus.req = '0;
    bus.theta_in = '0;
    bus.x_in = '0;
    bus.y_in = '0;
    repeat (3) @(negedge Clk);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_load", 32'(bus.eng_load), 32'd0);
    chk("rst_eng", 32'({bus.eng_theta, bus.eng_x, bus.eng_y}), 32'd0);
    chk("rst_res", 32'({bus.res_ax, bus.res_ay}), 32'd0);
    chk("rst_res_id", 32'(bus.res_id), 32'd0);
    reset = 1'b0;

    // single jobs, round-robin pointer carried from one entry to the next
    for (int i = 0; i < 7; i++) run_job(tv[i]);

    // all four requesting continuously from reset: order 0,1,2,3,0 every 12 cycles
    @(negedge Clk); reset = 1'b1;
    @(negedge Clk); reset = 1'b0;
    bus.theta_in = 32'h44332211;
    bus.x_in     = 32'h88776655;
    bus.y_in     = 32'hCCBBAA99;
    bus.req      = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_done(n);
      chk("rr_spacing", 32'(n), 32'(LAT));
      chk("rr_order", 32'(bus.done), 32'(4'b0001 << (j % 4)));
    end

    // reset while RUN holds cnt=4: everything back to reset values, no done
    @(negedge Clk);
    chk("rr_next_grant", 32'(bus.grant), 32'b0010);
    repeat (5) @(negedge Clk);
    reset = 1'b1;
    bus.req = '0;
    @(negedge Clk);
    chk("mid_rst_grant", 32'(bus.grant), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_load", 32'(bus.eng_load), 32'd0);
    chk("mid_rst_res", 32'({bus.res_ax, bus.res_ay}), 32'd0);
    chk("mid_rst_res_id", 32'(bus.res_id), 32'd0);
    reset = 1'b0;
    nz = 0;
    repeat (14) begin
      @(negedge Clk);
      if (bus.done != '0 || bus.busy) nz++;
    end
    chk("mid_rst_quiet", 32'(nz), 32'd0);
    run_job('{4'b1000, 8'h33, 8'h44, 8'h55, 3});

    // requester 2 drops req in its 3rd RUN cycle; requester 0 pending then
    @(negedge Clk);
    bus.theta_in = 32'h03020100;
    bus.x_in     = 32'h13121110;
    bus.y_in     = 32'h23222120;
    bus.req      = 4'b0100;
    @(negedge Clk);
    chk("drop_grant", 32'(bus.grant), 32'b0100);
    repeat (3) @(negedge Clk);
    bus.req = 4'b0001;
    n = 4;
    while (bus.done == '0 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    chk("drop_latency", 32'(n), 32'(LAT));
    chk("drop_done", 32'(bus.done), 32'b0100);
    chk("drop_res_id", 32'(bus.res_id), 32'd2);
    chk("drop_res_ax", 32'(bus.res_ax[15:8]), 32'h12);
    bus.x_in[7:0] = 8'h10;
    @(negedge Clk);
    chk("drop_next_grant", 32'(bus.grant), 32'b0001);
    chk("opchg_eng_x0", 32'(bus.eng_x), 32'h10);
    repeat (3) @(negedge Clk);
    bus.x_in[7:0] = 8'h7F;
    @(negedge Clk);
    chk("opchg_eng_x1", 32'(bus.eng_x), 32'h10);
    wait_done(n);
    chk("opchg_done", 32'(bus.done), 32'b0001);
    chk("opchg_eng_x2", 32'(bus.eng_x), 32'h10);
    chk("opchg_res_ax", 32'(bus.res_ax[15:8]), 32'h10);
    bus.req = '0;
    @(negedge Clk);

    // fairness: req[0] held, req[3] raised once during requester 0's job
    bus.req = 4'b0001;
    repeat (4) @(negedge Clk);
    chk("fair_grant0", 32'(bus.grant), 32'b0001);
    bus.req = 4'b1001;
    jobs = 0;
    got3 = 1'b0;
    while (!got3 && jobs < 3) begin
      wait_done(n);
      if (bus.done == '0) break;
      jobs++;
      if (bus.done[3]) got3 = 1'b1;
    end
    chk("fair_served3", 32'(got3), 32'd1);
    chk("fair_jobs", 32'(jobs), 32'd2);
    bus.req = '0;
    repeat (2) @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
